imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Sequences and shares the single-port instruction memory between two requesters: the pipeline fetch stage (read-only) and the program loader (write-only, used at boot and for debug patching). Sits between the IF stage/loader and the memory array. Issues one memory access per cycle, returns fetch data one cycle after grant, flags bad fetch addresses, and keeps the loader from starving fetch.

## Interface
- DEPTH, 64, memory depth in 32-bit words (power of two)
- AW, 6, word-index width, equal to log2(DEPTH)
- MAX_BURST, 4, consecutive loader grants allowed while a fetch waits
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch stage requests a read
- fetch_addr  in  32  byte address (PC)
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  fetch_data/fetch_err valid (registered)
- fetch_data  out  32  instruction word
- fetch_err  out  1  misaligned or out-of-range fetch
- load_req  in  1  loader requests a write
- load_addr  in  32  byte address
- load_data  in  32  word to write
- load_gnt  out  1  write accepted this cycle (combinational)
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write
- mem_addr  out  AW  word index, byte address [AW+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en
- load_count  out  16  words written since reset, saturating

## Operation
- States: RUN, LOAD, TURN.
- RUN: load_req has priority. If load_req, grant load and go to LOAD. Otherwise, if fetch_req, grant fetch and stay in RUN.
- LOAD: grant load while load_req=1. Starvation counter increments on each load grant while fetch_req=1. When it reaches MAX_BURST, the next cycle grants fetch instead of load and the counter clears. The counter clears whenever fetch_req=0. When load_req=0, go to TURN with no grant that cycle.
- TURN: no grants for one cycle (write-to-read turnaround), then go to RUN.
- Address check applies to both ports: bad if addr[1:0]≠0 or addr ≥ 4·DEPTH.
- Bad fetch: the request is granted, mem_en=0, and the next cycle gives fetch_valid=1, fetch_err=1, fetch_data=0 (NOP).
- Bad load: the request is granted and dropped (mem_en=0), and load_count does not increment.
- Good load: mem_en=1, mem_we=1, mem_wdata=load_data, load_count+1, saturating at 0xFFFF.
- Good fetch: mem_en=1, mem_we=0. The next cycle gives fetch_valid=1, fetch_err=0, fetch_data=mem_rdata.
- At most one grant per cycle; fetch_gnt and load_gnt are never both 1.

## Timing
- Reset (asynchronous assert, synchronous release): state RUN, starvation counter 0, load_count 0, fetch_valid 0, fetch_err 0, fetch_data 0. mem_en, mem_we, fetch_gnt and load_gnt are 0 while reset_n=0.
- Fetch latency: grant in cycle N, fetch_valid in cycle N+1 for exactly one cycle. Back-to-back fetches give one result per cycle.
- Requesters hold req/addr/data stable until they see their grant. Dropping req without a grant is legal and has no side effect.
- If fetch_req and load_req rise in the same cycle in RUN, load wins. Fetch waits at most MAX_BURST load cycles, or until the loader releases plus the TURN cycle.
- Reset mid-operation: any fetch_valid due in the next cycle is suppressed. A write granted in the reset cycle is not issued.
- TURN is always exactly one cycle, even if fetch_req and load_req are both high.

## Structure
- Shared package: state encoding (RUN/LOAD/TURN), NOP word constant 32'h00000000, and an address-check function (alignment + range against DEPTH).
- No sub-module. The starvation counter and load_count are inline registers.

## Test plan
- Reset, then fetch_req at 0x0, 0x4, 0x8 on consecutive cycles with mem holding 0x01098020, 0x014B8822, 0x02119020 → fetch_gnt each cycle; fetch_valid on the following cycles with those words in order; fetch_err=0.
- Fetch 0x6 and fetch 0x100 (DEPTH=64) → mem_en=0, fetch_valid=1, fetch_err=1, fetch_data=0 each.
- Load 0xAC0C0004 to 0xC → mem_we=1, mem_addr=3, load_count=1. Then one TURN cycle. Then fetch 0xC returns 0xAC0C0004.
- load_req held for 10 cycles with fetch_req held, MAX_BURST=4 → grant pattern L,L,L,L,F,L,L,L,L,F; then TURN; then fetch resumes.
- Simultaneous load_req and fetch_req from RUN → load_gnt=1, fetch_gnt=0, state LOAD.
- reset_n pulsed low in the cycle after a fetch grant → no fetch_valid; load_count returns to 0.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  // Word returned on a rejected fetch (executes as a no-op).
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // A byte address is usable when word aligned and inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (34'(addr) < (34'(depth) << 2));
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch (read) and loader (write).
// Handshake: a requester raises req with addr/data and holds them stable until it
// sees gnt=1 in the same cycle; gnt is combinational and at most one gnt is high per
// cycle. Dropping req before a grant is legal and has no effect.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [31:0]   fetch_data,
  output logic          fetch_err,
  input  logic          load_req,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_data,
  output logic          load_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [15:0]   load_count,
  output arb_state_t    dbg_state
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          fg, lg;
  logic          fetch_ok, load_ok;

  assign fetch_ok  = addr_ok(fetch_addr, DEPTH);
  assign load_ok   = addr_ok(load_addr, DEPTH);
  assign dbg_state = state_q;

  // Next-state and grant decision; load has priority except when fetch has starved.
  always_comb begin
    state_d = state_q;
    fg      = 1'b0;
    lg      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (load_req) begin
          lg      = 1'b1;
          state_d = ST_LOAD;
        end else if (fetch_req) begin
          fg = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!load_req) begin
          state_d = ST_TURN;
        end else if (fetch_req && (starve_q == CW'(MAX_BURST))) begin
          fg = 1'b1;
        end else begin
          lg = 1'b1;
        end
      end
      ST_TURN: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Count load grants that happened while a fetch was waiting; anything else clears it.
  always_comb begin
    starve_d = '0;
    if (fetch_req && lg) starve_d = starve_q + 1'b1;
  end

  // Grants and memory strobes are forced low while reset is asserted.
  assign fetch_gnt = reset_n & fg;
  assign load_gnt  = reset_n & lg;
  assign mem_en    = reset_n & ((fg & fetch_ok) | (lg & load_ok));
  assign mem_we    = reset_n & lg & load_ok;
  assign mem_addr  = lg ? load_addr[AW+1:2] : fetch_addr[AW+1:2];
  assign mem_wdata = load_data;

  // Read data arrives the cycle after the grant; rejected fetches return a NOP.
  assign fetch_data = (fetch_valid && !fetch_err) ? mem_rdata : NOP_WORD;

  // State register, starvation counter, fetch response flags and load counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      starve_q    <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      load_count  <= 16'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      fetch_valid <= fg;
      fetch_err   <= fg & ~fetch_ok;
      if (lg && load_ok && (load_count != 16'hFFFF)) load_count <= load_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a transaction-level model.
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int DEPTH     = 64;
  localparam int AW        = 6;
  localparam int MAX_BURST = 4;

  logic          clock;
  logic          reset_n;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          fetch_err;
  logic          load_req;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   load_count;
  arb_state_t    dbg_state;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_gnt(load_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_count(load_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory array stub with backdoor fill ----------------
  logic [31:0]   ram [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  always @(posedge clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_q[$];      // {err, data} of fetch results still to appear
  bit          m_owns;        // loader currently holds the memory
  bit          m_gap;         // one dead cycle after the loader lets go
  int          m_waited;      // loads granted while fetch kept waiting
  int          m_count;       // good words written since reset

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_good(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, 255)) | 32'h1;
    if (sel == 1) return 32'h100 + 32'($urandom_range(0, 63) * 4);
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  task automatic model_reset();
    m_owns = 0; m_gap = 0; m_waited = 0; m_count = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic drive_cycle(input bit fr, input logic [31:0] fa, input bit lr,
                             input logic [31:0] la, input logic [31:0] ld,
                             output bit gf, output bit gl);
    bit efg, elg, fok, lok;
    logic [32:0] e;
    @(negedge clock);
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la; load_data = ld;
    #2;
    efg = 0; elg = 0;
    if (m_gap) begin
      efg = 0;
    end else if (m_owns) begin
      if (lr && fr && m_waited >= MAX_BURST) efg = 1;
      else if (lr) elg = 1;
    end else if (lr) begin
      elg = 1;
    end else if (fr) begin
      efg = 1;
    end
    fok = addr_good(fa);
    lok = addr_good(la);

    check("fetch_gnt", 32'(fetch_gnt), 32'(efg));
    check("load_gnt", 32'(load_gnt), 32'(elg));
    check("one_grant", 32'(fetch_gnt & load_gnt), 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fetch_valid", 32'(fetch_valid), 32'd1);
      check("fetch_err", 32'(fetch_err), 32'(e[32]));
      check("fetch_data", fetch_data, e[31:0]);
    end else begin
      check("fetch_valid_idle", 32'(fetch_valid), 32'd0);
    end
    check("mem_en", 32'(mem_en), 32'((efg && fok) || (elg && lok)));
    check("mem_we", 32'(mem_we), 32'(elg && lok));
    if (efg && fok) check("mem_addr_rd", 32'(mem_addr), 32'(fa[AW+1:2]));
    if (elg && lok) begin
      check("mem_addr_wr", 32'(mem_addr), 32'(la[AW+1:2]));
      check("mem_wdata", mem_wdata, ld);
    end
    check("load_count", 32'(load_count), 32'(m_count));

    if (efg) exp_q.push_back(fok ? {1'b0, ref_mem[fa[AW+1:2]]} : {1'b1, 32'h0});
    if (elg && lok) begin
      ref_mem[la[AW+1:2]] = ld;
      if (m_count < 16'hFFFF) m_count++;
    end
    if (!fr || efg) m_waited = 0;
    else if (elg) m_waited++;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owns && !lr) begin
      m_owns = 0; m_gap = 1; m_waited = 0;
    end else if (elg) begin
      m_owns = 1;
    end
    gf = efg;
    gl = elg;
  endtask

  task automatic idle(input int n);
    bit gf, gl;
    for (int i = 0; i < n; i++) drive_cycle(0, 32'h0, 0, 32'h0, 32'h0, gf, gl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit gf, gl, fp, lp;
    bit [9:0] pat;
    bit [2:0] fpat;
    logic [31:0] fa, la, ld;
    int burst, tries;

    reset_n = 0; fetch_req = 0; fetch_addr = 0; load_req = 0; load_addr = 0; load_data = 0;
    bd_we = 0; bd_addr = '0; bd_data = 0;
    model_reset();

    // Backdoor fill while reset is held.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      bd_we = 1; bd_addr = AW'(i);
      bd_data = (i == 0) ? 32'h01098020 : (i == 1) ? 32'h014B8822 :
                (i == 2) ? 32'h02119020 : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clock);
    bd_we = 0;
    load_req = 1; load_addr = 32'h10; fetch_req = 1;
    #2;
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_fetch_data", fetch_data, 32'h0);
    check("rst_load_count", 32'(load_count), 32'd0);
    check("rst_gnts", 32'({fetch_gnt, load_gnt}), 32'd0);
    check("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_RUN));
    load_req = 0; fetch_req = 0;
    @(negedge clock);
    reset_n = 1;

    // Back-to-back fetches of the preloaded words.
    drive_cycle(1, 32'h0, 0, 0, 0, gf, gl);
    drive_cycle(1, 32'h4, 0, 0, 0, gf, gl);
    drive_cycle(1, 32'h8, 0, 0, 0, gf, gl);
    idle(1);

    // Misaligned and out-of-range fetches.
    drive_cycle(1, 32'h6, 0, 0, 0, gf, gl);
    drive_cycle(1, 32'h100, 0, 0, 0, gf, gl);
    idle(1);

    // Single load, then fetch it back after the turnaround.
    drive_cycle(0, 0, 1, 32'hC, 32'hAC0C0004, gf, gl);
    @(posedge clock); #1;
    check("load_count_one", 32'(load_count), 32'd1);
    tries = 0;
    gf = 0;
    while (!gf && tries < 5) begin
      drive_cycle(1, 32'hC, 0, 0, 0, gf, gl);
      tries++;
    end
    check("fetch_after_load_tries", 32'(tries), 32'd3);
    idle(2);

    // Simultaneous requests from RUN, then a held burst.
    pat = '0;
    drive_cycle(1, 32'h14, 1, 32'h20, $urandom, gf, gl);
    pat = {pat[8:0], gl};
    @(posedge clock); #1;
    check("simul_state_load", 32'(dbg_state), 32'(ST_LOAD));
    for (int i = 1; i < 10; i++) begin
      drive_cycle(1, 32'(4 * (i + 8)), 1, 32'(4 * (i + 32)), $urandom, gf, gl);
      pat = {pat[8:0], gl};
    end
    check("burst_pattern", 32'(pat), 32'h3DE);
    fpat = '0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 32'h18, 0, 0, 0, gf, gl);
      fpat = {fpat[1:0], gf};
    end
    check("release_pattern", 32'(fpat), 32'd1);
    idle(2);

    // Reset pulse the cycle after a fetch grant.
    drive_cycle(1, 32'h1C, 0, 0, 0, gf, gl);
    @(negedge clock);
    reset_n = 0; fetch_req = 0; load_req = 1; load_addr = 32'h24; load_data = 32'hDEADBEEF;
    #2;
    check("pulse_fetch_valid", 32'(fetch_valid), 32'd0);
    check("pulse_load_count", 32'(load_count), 32'd0);
    check("pulse_load_gnt", 32'(load_gnt), 32'd0);
    check("pulse_mem_en", 32'({mem_en, mem_we}), 32'd0);
    @(negedge clock);
    load_req = 0;
    reset_n = 1;
    model_reset();
    idle(2);

    // Randomized traffic with holding requesters.
    fp = 0; lp = 0; burst = 0; fa = 0; la = 0; ld = 0;
    for (int c = 0; c < 800; c++) begin
      if (!fp && $urandom_range(0, 3) != 0) begin fp = 1; fa = rand_addr(); end
      if (!lp && (burst > 0 || $urandom_range(0, 15) == 0)) begin
        if (burst == 0) burst = $urandom_range(1, 9);
        burst--;
        lp = 1; la = rand_addr(); ld = $urandom;
      end
      if (fp && $urandom_range(0, 31) == 0) fp = 0;
      drive_cycle(fp, fa, lp, la, ld, gf, gl);
      if (gf) fp = 0;
      if (gl) lp = 0;
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
